bram_debug_sequencer: RTL and testbench
=======================================

Name: bram_debug_sequencer

Overview:
- Hardware sequencer that owns the debug (port 2) side of the instruction and data BRAMs and the RV32Core reset line.
- Accepts commands to load either BRAM from a 32-bit word stream, run the core for a fixed number of cycles, or dump either BRAM to a 32-bit word stream.
- Replaces simulation-only load/run/dump sequencing with synthesizable logic, so a UART or host bridge can drive the core on the Nexys4 board.

Parameters:
- BRAM_WORDS, 4096, depth of each BRAM in 32-bit words; word counts are clamped to this value.
- READ_LATENCY, 1, cycles from a debug A2 change to valid RD2 data; legal range 1..3.
- RST_HOLD, 5, cycles core_rst is held high at the start of RUN.

Ports:
- CPU_CLK  in  1  clock
- CPU_RST_N  in  1  synchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer idle and can accept a command
- cmd_op  in  3  0=LOAD_I, 1=LOAD_D, 2=DUMP_I, 3=DUMP_D, 4=RUN; 5..7 illegal
- cmd_count  in  13  word count for LOAD/DUMP (0..4096)
- cmd_cycles  in  32  run length in cycles for RUN
- in_valid / in_ready / in_data  in/out/in  1/1/32  load word stream
- out_valid / out_ready / out_data / out_last  out/in/out/out  1/1/32/1  dump word stream
- core_rst  out  1  drives RV32Core CPU_RST (active-high)
- iram_a2, iram_wd2  out  32 each  instruction BRAM debug address / write data
- iram_we2  out  4  instruction BRAM debug byte write enables
- iram_rd2  in  32  instruction BRAM debug read data
- dram_a2, dram_wd2, dram_we2, dram_rd2  same as iram_*  data BRAM debug port
- busy  out  1  not in IDLE
- done  out  1  one-cycle pulse when a command completes
- err  out  1  one-cycle pulse, coincident with done, for an illegal op

Behaviour:
- Reset values (CPU_RST_N low at a CPU_CLK edge): state=IDLE; core_rst=1; all a2/wd2/we2=0; in_ready=0; out_valid=0; out_last=0; out_data=0; busy=0; done=0; err=0; all counters 0. A reset mid-command aborts it immediately, with no done pulse.
- cmd_ready = (state==IDLE). A command is accepted on cmd_valid && cmd_ready; cmd_op, cmd_count and cmd_cycles are latched on that edge.
- Effective count n = min(cmd_count, BRAM_WORDS). If n=0 for LOAD/DUMP, done pulses in the cycle after acceptance.
- Illegal op: done=1 and err=1 in the cycle after acceptance, then IDLE.
- States: IDLE -> LOAD | RUN_RST | DUMP_ADDR. LOAD -> FIN. RUN_RST -> RUN -> FIN. DUMP_ADDR -> DUMP_WAIT -> DUMP_OUT -> DUMP_ADDR or FIN. FIN pulses done and returns to IDLE.
- LOAD:
  - in_ready=1 while fewer than n words have been accepted.
  - The k-th handshake (k from 0) registers a2=4k, wd2=in_data and we2=4'b1111 on the selected RAM for exactly one cycle; we2=0 otherwise.
  - After the n-th write, go to FIN; done is asserted the cycle after the last we2 pulse.
  - The unselected RAM's port stays idle (we2=0).
  - core_rst stays 1 throughout.
- RUN:
  - core_rst=1 for RST_HOLD cycles (RUN_RST).
  - core_rst=0 for exactly cmd_cycles cycles; cmd_cycles=0 means zero run cycles.
  - core_rst returns to 1 in the same edge as the move to FIN.
  - Both debug ports are held idle during RUN.
- DUMP, for each word k:
  - DUMP_ADDR: drive a2=4k.
  - DUMP_WAIT: wait READ_LATENCY cycles.
  - Capture rd2 into out_data and assert out_valid. out_last=1 when k=n-1.
  - out_valid, out_data and out_last are held stable until out_ready.
  - The handshake advances k. Back-pressure may last indefinitely.
- Address arithmetic: 32-bit byte addresses, step 4, never wraps because n ≤ BRAM_WORDS. Counters are 13 bits wide.
- busy=1 in every state except IDLE.

Decomposition:
- Shared package bram_dbg_pkg:
  - op encodings: OP_LOAD_I, OP_LOAD_D, OP_DUMP_I, OP_DUMP_D, OP_RUN
  - state enum
  - BRAM_WORDS default
- One sub-module, bram_dbg_port_mux: steers a single internal a2/wd2/we2 bundle to iram_* or dram_* by a RAM-select bit, and selects the matching rd2. Non-selected outputs are forced to 0.

Test Plan:
- Reset: hold CPU_RST_N low 3 cycles mid-LOAD -> all outputs at reset values, core_rst=1, no done pulse; next command accepted normally.
- LOAD_D, n=3, words 0x11111111, 0x22222222, 0x33333333 with a 2-cycle in_valid gap -> dram_we2=4'hF pulses at a2=0,4,8 with matching wd2; iram_we2 stays 0; one done pulse.
- DUMP_I, n=2 with iram_rd2 model = address xor 0xA5A5A5A5, out_ready low 4 cycles on word 0 -> out_data 0xA5A5A5A5 held stable, then 0xA5A5A5A1 with out_last=1; done follows.
- RUN, cmd_cycles=10, RST_HOLD=5 -> core_rst high 5 cycles, low exactly 10 cycles, then high; done pulses once.
- cmd_count=5000 on LOAD_I -> exactly 4096 writes, last at a2=0x3FFC; cmd_count=0 -> done the cycle after acceptance, no writes.
- cmd_op=6 -> done and err together for 1 cycle; no port activity; cmd_ready returns the next cycle.

Source files
------------

// File: rtl/bram_dbg_pkg.sv
// Shared encodings and helpers for the BRAM debug sequencer.
package bram_dbg_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned CNT_W          = 13;
    localparam int unsigned BRAM_WORDS_DEF = 4096;

    // Command opcodes; 5..7 are illegal.
    localparam logic [2:0] OP_LOAD_I = 3'd0;
    localparam logic [2:0] OP_LOAD_D = 3'd1;
    localparam logic [2:0] OP_DUMP_I = 3'd2;
    localparam logic [2:0] OP_DUMP_D = 3'd3;
    localparam logic [2:0] OP_RUN    = 3'd4;

    // Sequencer states.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD      = 3'd1;
    localparam logic [2:0] ST_RUN_RST   = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_DUMP_ADDR = 3'd4;
    localparam logic [2:0] ST_DUMP_WAIT = 3'd5;
    localparam logic [2:0] ST_DUMP_OUT  = 3'd6;
    localparam logic [2:0] ST_FIN       = 3'd7;

    // Clamp a requested word count to the BRAM depth.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] cnt,
                                                     input int unsigned       lim);
        if (32'(cnt) > lim) return CNT_W'(lim);
        return cnt;
    endfunction

    // Byte address of word k.
    function automatic logic [XLEN-1:0] word_addr(input logic [CNT_W-1:0] k);
        return XLEN'(k) << 2;
    endfunction

endpackage

// File: rtl/bram_dbg_port_mux.sv
// Steers one internal debug-port bundle onto the instruction or data BRAM.
module bram_dbg_port_mux
    import bram_dbg_pkg::*;
(
    input  logic            sel_i,       // 0 = instruction BRAM, 1 = data BRAM
    input  logic [XLEN-1:0] a2_i,
    input  logic [XLEN-1:0] wd2_i,
    input  logic [3:0]      we2_i,
    output logic [XLEN-1:0] rd2_o,
    output logic [XLEN-1:0] iram_a2_o,
    output logic [XLEN-1:0] iram_wd2_o,
    output logic [3:0]      iram_we2_o,
    input  logic [XLEN-1:0] iram_rd2_i,
    output logic [XLEN-1:0] dram_a2_o,
    output logic [XLEN-1:0] dram_wd2_o,
    output logic [3:0]      dram_we2_o,
    input  logic [XLEN-1:0] dram_rd2_i
);

    // Drive only the selected port; the other is held at zero.
    always_comb begin
        iram_a2_o  = '0;
        iram_wd2_o = '0;
        iram_we2_o = '0;
        dram_a2_o  = '0;
        dram_wd2_o = '0;
        dram_we2_o = '0;
        if (sel_i) begin
            dram_a2_o  = a2_i;
            dram_wd2_o = wd2_i;
            dram_we2_o = we2_i;
        end else begin
            iram_a2_o  = a2_i;
            iram_wd2_o = wd2_i;
            iram_we2_o = we2_i;
        end
        rd2_o = sel_i ? dram_rd2_i : iram_rd2_i;
    end

endmodule

// File: rtl/bram_debug_sequencer.sv
// Load/run/dump sequencer owning the BRAM debug ports and the core reset.
module bram_debug_sequencer
    import bram_dbg_pkg::*;
#(
    parameter int unsigned BRAM_WORDS   = BRAM_WORDS_DEF,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned RST_HOLD     = 5
) (
    input  logic            CPU_CLK,
    input  logic            CPU_RST_N,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [2:0]      cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [31:0]     cmd_cycles,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic            out_last,
    output logic            core_rst,
    output logic [XLEN-1:0] iram_a2,
    output logic [XLEN-1:0] iram_wd2,
    output logic [3:0]      iram_we2,
    input  logic [XLEN-1:0] iram_rd2,
    output logic [XLEN-1:0] dram_a2,
    output logic [XLEN-1:0] dram_wd2,
    output logic [3:0]      dram_we2,
    input  logic [XLEN-1:0] dram_rd2,
    output logic            busy,
    output logic            done,
    output logic            err
);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, n_q, n_d;
    logic [31:0]      cyc_q, cyc_d, tmr_q, tmr_d;
    logic             sel_q, sel_d;
    logic [XLEN-1:0]  a2_q, a2_d, wd2_q, wd2_d, out_data_q, out_data_d;
    logic [3:0]       we2_q, we2_d;
    logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d, core_rst_q, core_rst_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic [XLEN-1:0]  rd2_sel;
    logic [CNT_W-1:0] n_req;
    logic             accept, in_hs, out_hs;

    assign accept = cmd_valid && cmd_ready_q;
    assign in_hs  = in_valid && in_ready_q;
    assign out_hs = out_valid_q && out_ready;
    assign n_req  = clamp_count(cmd_count, BRAM_WORDS);

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        cyc_d      = cyc_q;
        tmr_d      = tmr_q;
        sel_d      = sel_q;
        a2_d       = a2_q;
        wd2_d      = wd2_q;
        we2_d      = '0;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    n_d   = n_req;
                    cyc_d = cmd_cycles;
                    sel_d = cmd_op[0];
                    cnt_d = '0;
                    tmr_d = '0;
                    a2_d  = '0;
                    wd2_d = '0;
                    case (cmd_op)
                        OP_LOAD_I, OP_LOAD_D: state_d = (n_req == '0) ? ST_FIN : ST_LOAD;
                        OP_DUMP_I, OP_DUMP_D: state_d = (n_req == '0) ? ST_FIN : ST_DUMP_ADDR;
                        OP_RUN:               state_d = ST_RUN_RST;
                        default: begin
                            state_d = ST_FIN;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            ST_LOAD: begin
                if (in_hs) begin
                    a2_d  = word_addr(cnt_q);
                    wd2_d = in_data;
                    we2_d = 4'b1111;
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (cnt_q == n_q) begin
                    state_d = ST_FIN;
                end
            end
            ST_RUN_RST: begin
                if (tmr_q == 32'(RST_HOLD - 1)) begin
                    tmr_d   = '0;
                    state_d = (cyc_q == '0) ? ST_FIN : ST_RUN;
                end else begin
                    tmr_d = tmr_q + 32'd1;
                end
            end
            ST_RUN: begin
                if (tmr_q == cyc_q - 32'd1) state_d = ST_FIN;
                else                        tmr_d   = tmr_q + 32'd1;
            end
            ST_DUMP_ADDR: begin
                tmr_d   = '0;
                state_d = ST_DUMP_WAIT;
            end
            ST_DUMP_WAIT: begin
                if (tmr_q == 32'(READ_LATENCY - 1)) begin
                    state_d    = ST_DUMP_OUT;
                    out_data_d = rd2_sel;
                    out_last_d = (cnt_q == n_q - CNT_W'(1));
                end else begin
                    tmr_d = tmr_q + 32'd1;
                end
            end
            ST_DUMP_OUT: begin
                if (out_hs) begin
                    out_last_d = 1'b0;
                    if (cnt_q == n_q - CNT_W'(1)) begin
                        state_d = ST_FIN;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        a2_d    = word_addr(cnt_d);
                        state_d = ST_DUMP_ADDR;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                a2_d    = '0;
                wd2_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d  = (state_d == ST_LOAD) && (cnt_d < n_d);
        out_valid_d = (state_d == ST_DUMP_OUT);
        core_rst_d  = (state_d != ST_RUN);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_FIN);
        cmd_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CPU_CLK) begin
        if (!CPU_RST_N) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            cyc_q       <= '0;
            tmr_q       <= '0;
            sel_q       <= 1'b0;
            a2_q        <= '0;
            wd2_q       <= '0;
            we2_q       <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            core_rst_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            cyc_q       <= cyc_d;
            tmr_q       <= tmr_d;
            sel_q       <= sel_d;
            a2_q        <= a2_d;
            wd2_q       <= wd2_d;
            we2_q       <= we2_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            core_rst_q  <= core_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign core_rst  = core_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

    bram_dbg_port_mux u_mux (
        .sel_i      (sel_q),
        .a2_i       (a2_q),
        .wd2_i      (wd2_q),
        .we2_i      (we2_q),
        .rd2_o      (rd2_sel),
        .iram_a2_o  (iram_a2),
        .iram_wd2_o (iram_wd2),
        .iram_we2_o (iram_we2),
        .iram_rd2_i (iram_rd2),
        .dram_a2_o  (dram_a2),
        .dram_wd2_o (dram_wd2),
        .dram_we2_o (dram_we2),
        .dram_rd2_i (dram_rd2)
    );

endmodule

// File: tb/tb_bram_debug_sequencer.sv
// Scoreboard bench for bram_debug_sequencer.
module tb_bram_debug_sequencer;
    import bram_dbg_pkg::*;

    localparam int EV_WR_I = 0;
    localparam int EV_WR_D = 1;
    localparam int EV_OUT  = 2;
    localparam int EV_DONE = 3;

    logic        CPU_CLK = 1'b0;
    logic        CPU_RST_N;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_op;
    logic [12:0] cmd_count;
    logic [31:0] cmd_cycles;
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic        out_valid, out_ready, out_last;
    logic [31:0] out_data;
    logic        core_rst;
    logic [31:0] iram_a2, iram_wd2, iram_rd2, dram_a2, dram_wd2, dram_rd2;
    logic [3:0]  iram_we2, dram_we2;
    logic        busy, done, err;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    always #5 CPU_CLK = ~CPU_CLK;

    // One-cycle-latency BRAM read models.
    always @(posedge CPU_CLK) begin
        iram_rd2 <= iram_a2 ^ 32'hA5A5A5A5;
        dram_rd2 <= dram_a2 ^ 32'h5A5A5A5A;
    end

    bram_debug_sequencer dut (
        .CPU_CLK(CPU_CLK), .CPU_RST_N(CPU_RST_N),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_count(cmd_count), .cmd_cycles(cmd_cycles),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .core_rst(core_rst),
        .iram_a2(iram_a2), .iram_wd2(iram_wd2), .iram_we2(iram_we2), .iram_rd2(iram_rd2),
        .dram_a2(dram_a2), .dram_wd2(dram_wd2), .dram_we2(dram_we2), .dram_rd2(dram_rd2),
        .busy(busy), .done(done), .err(err)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void push(input int kind, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        e.d    = d;
        exp_q.push_back(e);
    endfunction

    task automatic observe(input int kind, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_event_kind", 32'(kind), 32'hFFFFFFFF);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", 32'(kind), 32'(e.kind));
            chk("event_a", a, e.a);
            chk("event_d", d, e.d);
        end
    endtask

    // Monitor: every write pulse, dump handshake and done pulse is scored.
    always @(negedge CPU_CLK) begin
        if (iram_we2 != 4'h0) begin
            chk("iram_we2_mask", 32'(iram_we2), 32'hF);
            observe(EV_WR_I, iram_a2, iram_wd2);
        end
        if (dram_we2 != 4'h0) begin
            chk("dram_we2_mask", 32'(dram_we2), 32'hF);
            observe(EV_WR_D, dram_a2, dram_wd2);
        end
        if (out_valid && out_ready) observe(EV_OUT, 32'(out_last), out_data);
        if (done) observe(EV_DONE, 32'(err), 32'h0);
        if (err && !done) chk("err_without_done", 32'(done), 32'h1);
    end

    task automatic tick();
        @(posedge CPU_CLK);
        #1;
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [12:0] cnt, input logic [31:0] cyc);
        int g = 0;
        cmd_op = op; cmd_count = cnt; cmd_cycles = cyc; cmd_valid = 1'b1;
        while (!cmd_ready && g < 50) begin tick(); g++; end
        if (!cmd_ready) chk("cmd_ready_timeout", 32'(cmd_ready), 32'h1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic feed(input logic [31:0] w, input int gap);
        int g = 0;
        in_data = w; in_valid = 1'b1;
        while (!in_ready && g < 50) begin tick(); g++; end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic wait_done(input string name, input int budget);
        int g = 0;
        while (!done && g < budget) begin tick(); g++; end
        chk(name, 32'(done), 32'h1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_core_rst"}, 32'(core_rst), 32'h1);
        chk({tag, "_busy_done_err"}, {29'd0, busy, done, err}, 32'h0);
        chk({tag, "_streams"}, {29'd0, in_ready, out_valid, out_last}, 32'h0);
        chk({tag, "_out_data"}, out_data, 32'h0);
        chk({tag, "_ports"}, iram_a2 | iram_wd2 | dram_a2 | dram_wd2 | 32'(iram_we2) | 32'(dram_we2), 32'h0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, lo, g;
        CPU_RST_N = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_count = '0; cmd_cycles = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) tick();
        check_reset("rst0");
        CPU_RST_N = 1'b1;
        tick();

        // Reset in the middle of a LOAD aborts it with no done pulse.
        push(EV_WR_I, 32'h0, 32'hDEAD0000);
        push(EV_WR_I, 32'h4, 32'hDEAD0001);
        send_cmd(OP_LOAD_I, 13'd4, 32'd0);
        feed(32'hDEAD0000, 0);
        feed(32'hDEAD0001, 0);
        chk("midload_busy", 32'(busy), 32'h1);
        CPU_RST_N = 1'b0;
        repeat (3) tick();
        check_reset("rst_mid");
        CPU_RST_N = 1'b1;
        tick();
        chk("abort_no_done", 32'(done), 32'h0);
        chk("abort_queue_empty", 32'(exp_q.size()), 32'h0);

        // LOAD_D of three words with gaps.
        push(EV_WR_D, 32'h0, 32'h11111111);
        push(EV_WR_D, 32'h4, 32'h22222222);
        push(EV_WR_D, 32'h8, 32'h33333333);
        push(EV_DONE, 32'h0, 32'h0);
        send_cmd(OP_LOAD_D, 13'd3, 32'd0);
        feed(32'h11111111, 2);
        feed(32'h22222222, 2);
        feed(32'h33333333, 0);
        chk("load_d_last_we", 32'(dram_we2), 32'hF);
        chk("load_d_iram_idle", 32'(iram_we2), 32'h0);
        chk("load_d_done_not_yet", 32'(done), 32'h0);
        tick();
        chk("load_d_done_after_we", 32'(done), 32'h1);
        tick();
        chk("load_d_done_one_cycle", 32'(done), 32'h0);
        chk("load_d_ready_again", 32'(cmd_ready), 32'h1);

        // DUMP_I of two words with back-pressure on the first.
        push(EV_OUT, 32'h0, 32'hA5A5A5A5);
        push(EV_OUT, 32'h1, 32'hA5A5A5A1);
        push(EV_DONE, 32'h0, 32'h0);
        out_ready = 1'b0;
        send_cmd(OP_DUMP_I, 13'd2, 32'd0);
        g = 0;
        while (!out_valid && g < 20) begin tick(); g++; end
        chk("dump_valid0", 32'(out_valid), 32'h1);
        for (int i = 0; i < 4; i++) begin
            chk("dump_hold_data", out_data, 32'hA5A5A5A5);
            chk("dump_hold_valid_last", {30'd0, out_valid, out_last}, 32'h2);
            tick();
        end
        out_ready = 1'b1;
        tick();
        g = 0;
        while (!out_valid && g < 20) begin tick(); g++; end
        chk("dump_word1_data", out_data, 32'hA5A5A5A1);
        chk("dump_word1_last", 32'(out_last), 32'h1);
        tick();
        out_ready = 1'b0;
        wait_done("dump_done", 10);
        tick();

        // RUN for ten cycles.
        push(EV_DONE, 32'h0, 32'h0);
        send_cmd(OP_RUN, 13'd0, 32'd10);
        hi = 0;
        while (core_rst && hi < 50) begin hi++; tick(); end
        chk("run_rst_hold", 32'(hi), 32'd5);
        lo = 0;
        while (!core_rst && lo < 50) begin
            chk("run_ports_idle", 32'(iram_we2) | 32'(dram_we2) | iram_a2 | dram_a2, 32'h0);
            lo++; tick();
        end
        chk("run_low_cycles", 32'(lo), 32'd10);
        chk("run_done_with_rst", 32'(done), 32'h1);
        tick();

        // LOAD_I with count above depth is clamped.
        for (int k = 0; k < 4096; k++) push(EV_WR_I, 32'(k) << 2, 32'hC0DE0000 ^ 32'(k));
        push(EV_DONE, 32'h0, 32'h0);
        send_cmd(OP_LOAD_I, 13'd5000, 32'd0);
        for (int k = 0; k < 4096; k++) feed(32'hC0DE0000 ^ 32'(k), 0);
        chk("clamp_in_ready_low", 32'(in_ready), 32'h0);
        chk("clamp_last_addr", iram_a2, 32'h3FFC);
        tick();
        chk("clamp_done", 32'(done), 32'h1);
        tick();

        // Zero-count load completes immediately.
        push(EV_DONE, 32'h0, 32'h0);
        send_cmd(OP_LOAD_I, 13'd0, 32'd0);
        chk("zero_done", 32'(done), 32'h1);
        chk("zero_no_write", 32'(iram_we2) | 32'(dram_we2), 32'h0);
        tick();
        chk("zero_ready_again", 32'(cmd_ready), 32'h1);

        // Illegal opcode.
        push(EV_DONE, 32'h1, 32'h0);
        send_cmd(3'd6, 13'd7, 32'd0);
        chk("illegal_done_err", {30'd0, done, err}, 32'h3);
        chk("illegal_not_ready", 32'(cmd_ready), 32'h0);
        chk("illegal_no_ports", 32'(iram_we2) | 32'(dram_we2) | 32'(in_ready) | 32'(out_valid), 32'h0);
        tick();
        chk("illegal_ready_next", 32'(cmd_ready), 32'h1);
        chk("illegal_pulse_width", {30'd0, done, err}, 32'h0);

        repeat (3) tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
